// File: rtl/pipe_pkg.sv
// Shared pipeline types: ID/EX control word, stall-cause encoding and ID/EX FSM states.
package pipe_pkg;

  localparam int CTRL_W = 8;

  localparam int CTRL_REG_WRITE  = 7;
  localparam int CTRL_MEM_READ   = 6;
  localparam int CTRL_MEM_WRITE  = 5;
  localparam int CTRL_MEM_TO_REG = 4;
  localparam int CTRL_ALU_SRC    = 3;
  localparam int CTRL_REG_DST    = 2;
  localparam int CTRL_ALU_OP_MSB = 1;
  localparam int CTRL_ALU_OP_LSB = 0;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_dst;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_LOAD_USE = 2'd1;
  localparam logic [1:0] CAUSE_MEM_HOLD = 2'd2;
  localparam logic [1:0] CAUSE_FLUSH    = 2'd3;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    BUBBLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use comparator: a load in EX whose destination is read by the ID instruction.
module load_use_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] rs_id,
  input  logic [REG_AW-1:0] rt_id,
  input  logic              uses_rt_id,
  output logic              hazard
);

  logic rt_nonzero;
  logic rs_match;
  logic rt_match;

  assign rt_nonzero = (ex_rt != '0);
  assign rs_match   = (ex_rt == rs_id);
  assign rt_match   = uses_rt_id && (ex_rt == rt_id);
  assign hazard     = ex_valid && ex_mem_read && rt_nonzero && (rs_match || rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush bubble and memory-hold freeze.
// Optional macro STALL_STATS_EN adds a saturating stall_cycles counter output.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs_id,
  input  logic [REG_AW-1:0] rt_id,
  input  logic [REG_AW-1:0] rd_id,
  input  logic [DATA_W-1:0] read_data1_id,
  input  logic [DATA_W-1:0] read_data2_id,
  input  logic [DATA_W-1:0] imm_id,
  input  ctrl_t             ctrl_id,
  input  logic              uses_rt_id,
  input  logic              flush,
  input  logic              mem_busy,
  output logic              stall,
  output logic [1:0]        stall_cause,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_read_data1,
  output logic [DATA_W-1:0] ex_read_data2,
  output logic [DATA_W-1:0] ex_imm,
  output ctrl_t             ex_ctrl,
  output logic              ex_valid
`ifdef STALL_STATS_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  state_t state;
  state_t state_nxt;
  logic   hazard;
  logic   load_bubble;

  load_use_detect #(
    .REG_AW(REG_AW)
  ) u_load_use_detect (
    .ex_valid   (ex_valid),
    .ex_mem_read(ex_ctrl.mem_read),
    .ex_rt      (ex_rt),
    .rs_id      (rs_id),
    .rt_id      (rt_id),
    .uses_rt_id (uses_rt_id),
    .hazard     (hazard)
  );

  // Priority rst > mem_busy > flush > load-use > normal; leaving HOLD falls
  // straight through the same priority, so the hazard is re-evaluated then.
  always_comb begin
    stall       = 1'b0;
    stall_cause = CAUSE_NONE;
    load_bubble = 1'b0;
    state_nxt   = state;
    if (rst) begin
      state_nxt = RUN;
    end else if (mem_busy) begin
      stall       = 1'b1;
      stall_cause = CAUSE_MEM_HOLD;
      state_nxt   = HOLD;
    end else if (flush) begin
      stall_cause = CAUSE_FLUSH;
      load_bubble = 1'b1;
      state_nxt   = BUBBLE;
    end else if (hazard) begin
      stall       = 1'b1;
      stall_cause = CAUSE_LOAD_USE;
      load_bubble = 1'b1;
      state_nxt   = BUBBLE;
    end else begin
      state_nxt = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (!mem_busy && load_bubble)) begin
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_rd         <= '0;
      ex_read_data1 <= '0;
      ex_read_data2 <= '0;
      ex_imm        <= '0;
      ex_ctrl       <= '0;
      ex_valid      <= 1'b0;
    end else if (!mem_busy) begin
      ex_rs         <= rs_id;
      ex_rt         <= rt_id;
      ex_rd         <= rd_id;
      ex_read_data1 <= read_data1_id;
      ex_read_data2 <= read_data2_id;
      ex_imm        <= imm_id;
      ex_ctrl       <= ctrl_id;
      ex_valid      <= 1'b1;
    end
  end

`ifdef STALL_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, datapath width.
REQ-002 The block SHALL have parameter REG_AW, default 5, register-address width.
REQ-003 clk  input  1  rising-edge clock; single clock domain.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 rs_id, rt_id, rd_id  input  REG_AW each  ID-stage register specifiers.
REQ-006 read_data1_id, read_data2_id  input  DATA_W each  operands from the write-back forwarding outputs.
REQ-007 imm_id  input  DATA_W  sign-extended immediate.
REQ-008 ctrl_id  input  ctrl_t (8)  {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, RegDst, ALUOp[1:0]}.
REQ-009 uses_rt_id  input  1  ID instruction reads rt as a source.
REQ-010 flush  input  1  taken branch/jump resolved in EX.
REQ-011 mem_busy  input  1  data memory not ready; whole pipeline freezes.
REQ-012 stall  output  1  freeze PC and IF/ID register (combinational).
REQ-013 stall_cause  output  2  0 none, 1 load-use, 2 mem hold, 3 flush.
REQ-014 ex_rs, ex_rt, ex_rd  output  REG_AW each; ex_read_data1, ex_read_data2, ex_imm  output  DATA_W each; ex_ctrl  output  ctrl_t; ex_valid  output  1 -- registered ID/EX contents.

Function
REQ-015 Load-use hazard SHALL be: ex_valid & ex_ctrl.MemRead & ex_rt!=0 & (ex_rt==rs_id | (uses_rt_id & ex_rt==rt_id)).
REQ-016 Per-cycle priority SHALL be: rst > mem_busy > flush > load-use > normal.
REQ-017 mem_busy: all ID/EX registers SHALL hold; stall=1; stall_cause=2.
REQ-018 flush: ID/EX SHALL load a bubble (ex_ctrl=0, ex_valid=0, data/specifiers=0); stall=0; stall_cause=3.
REQ-019 load-use: ID/EX SHALL load a bubble; stall=1; stall_cause=1.
REQ-020 Normal: ID/EX SHALL load all *_id inputs next edge with ex_valid=1; stall=0; stall_cause=0.
REQ-021 The FSM SHALL have states RUN, BUBBLE (bubble occupies EX), HOLD (frozen); RUN->BUBBLE on flush or load-use; RUN/BUBBLE->HOLD on mem_busy; HOLD returns to the held state's successor per REQ-016 when mem_busy drops; BUBBLE->RUN on normal load.
REQ-022 A load-use stall SHALL last exactly one cycle, since the bubble clears MemRead in EX.
REQ-023 Consecutive loads to the same register SHALL each stall one cycle independently.
REQ-024 Register 0 as ex_rt SHALL never cause a stall.
REQ-025 mem_busy asserted in the same cycle as a hazard SHALL hold; the hazard is re-evaluated once mem_busy drops.

Reset
REQ-026 rst SHALL clear all ex_* outputs to 0, ex_valid to 0, state to RUN; stall and stall_cause SHALL be 0 while rst=1.
REQ-027 rst asserted during HOLD or BUBBLE SHALL override and discard the state on the next edge.

Configuration
REQ-028 Macro STALL_STATS_EN SHALL, when defined, add output stall_cycles (32) counting cycles with stall=1, saturating at 32'hFFFFFFFF and cleared by rst.
REQ-029 Without STALL_STATS_EN the port and counter SHALL be absent, with no other behavioural change.

Structure
REQ-030 Package pipe_pkg SHALL hold ctrl_t, CTRL_W=8, the control-bit positions, the stall_cause encoding, and the FSM state enum.
REQ-031 The combinational hazard comparator SHALL be a sub-module named load_use_detect; the registers and FSM stay in id_ex_stage.

Verification
REQ-032 The bench SHALL cover: lw $8 in EX, ID add rs=8 -> stall=1, cause=1, next cycle ex_ctrl=0, ex_valid=0, then stall=0.
REQ-033 The bench SHALL cover: lw rt=0 in EX, ID rs=0 -> stall=0, normal load.
REQ-034 The bench SHALL cover: lw $5 in EX, ID rt=5 with uses_rt_id=0 -> no stall; with uses_rt_id=1 -> stall=1.
REQ-035 The bench SHALL cover: flush=1 together with a load-use hazard -> stall=0, cause=3, bubble loaded.
REQ-036 The bench SHALL cover: mem_busy high 3 cycles with ex_rd=9 -> outputs unchanged for 3 cycles, stall=1, cause=2; with STALL_STATS_EN, stall_cycles +3.
REQ-037 The bench SHALL cover: rst asserted mid-HOLD -> all ex_* are 0 and state is RUN after one edge.
